// File: rtl/wb_timer_pkg.sv
// Register map, bit positions and shared types for the wb_timer Wishbone peripheral.
package wb_timer_pkg;

    localparam int unsigned ADR_W    = 15;
    localparam int unsigned DAT_W    = 32;
    localparam int unsigned OFS_W    = 4;
    localparam int unsigned NUM_CHAN = 2;

    localparam logic [OFS_W-1:0] REG_CTRL     = 4'd0;
    localparam logic [OFS_W-1:0] REG_PRESCALE = 4'd1;
    localparam logic [OFS_W-1:0] REG_RELOAD0  = 4'd2;
    localparam logic [OFS_W-1:0] REG_RELOAD1  = 4'd3;
    localparam logic [OFS_W-1:0] REG_COUNT0   = 4'd4;
    localparam logic [OFS_W-1:0] REG_COUNT1   = 4'd5;
    localparam logic [OFS_W-1:0] REG_STATUS   = 4'd6;
    localparam logic [OFS_W-1:0] REG_ID       = 4'd7;

    localparam int unsigned CTRL_EN0 = 0;
    localparam int unsigned CTRL_EN1 = 1;
    localparam int unsigned CTRL_AR0 = 2;
    localparam int unsigned CTRL_AR1 = 3;

    localparam int unsigned STAT_EXP0 = 0;
    localparam int unsigned STAT_EXP1 = 1;

    // Field order mirrors the CTRL register layout (bit 3 down to bit 0).
    typedef struct packed {
        logic ar1;
        logic ar0;
        logic en1;
        logic en0;
    } ctrl_t;

endpackage

// File: rtl/wbt_chan.sv
// One countdown channel: COUNT/RELOAD storage, decrement on tick, expiry and auto-reload.
module wbt_chan
    import wb_timer_pkg::*;
(
    input  logic             clk,
    input  logic             arstn,
    input  logic             tick,
    input  logic             en,
    input  logic             ar,
    input  logic             ld_count,
    input  logic             ld_reload,
    input  logic [DAT_W-1:0] wdata,
    output logic [DAT_W-1:0] count,
    output logic [DAT_W-1:0] reload,
    output logic             expire_c,
    output logic             en_clr_c
);

    logic             zero_c;
    logic             step_c;
    logic [DAT_W-1:0] count_nxt_c;

    // A bus load of COUNT takes precedence over the tick in the same cycle.
    assign zero_c   = (count == '0);
    assign step_c   = tick & en & ~ld_count;
    assign expire_c = step_c & zero_c;
    assign en_clr_c = expire_c & ~ar;

    always_comb begin
        count_nxt_c = count;
        if (ld_count) begin
            count_nxt_c = wdata;
        end else if (step_c) begin
            if (zero_c) begin
                count_nxt_c = ar ? reload : '0;
            end else begin
                count_nxt_c = count - DAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            count  <= '0;
            reload <= '0;
        end else begin
            count <= count_nxt_c;
            if (ld_reload) begin
                reload <= wdata;
            end
        end
    end

endmodule

// File: rtl/wb_timer.sv
// Wishbone slave with a shared prescaler and two 32-bit countdown timers raising irq strobes.
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter logic [10:0] BASEADR  = 11'h000,
    parameter int unsigned PRE_BITS = 16,
    parameter logic [31:0] ID       = 32'h574B5431
) (
    input  logic              clk,
    input  logic              arstn,
    input  logic [ADR_W-1:0]  adr_i,
    input  logic [DAT_W-1:0]  dat_i,
    output logic [DAT_W-1:0]  dat_o,
    input  logic              we_i,
    input  logic              stb_i,
    output logic              ack_o,
    output logic [NUM_CHAN-1:0] irq_o
);

    logic                sel_c;
    logic                commit_c;
    logic                wr_c;
    logic                rd_c;
    logic [OFS_W-1:0]    ofs;

    logic                wr_ctrl_c;
    logic                wr_pre_c;
    logic                wr_stat_c;
    logic [NUM_CHAN-1:0] ld_count_c;
    logic [NUM_CHAN-1:0] ld_reload_c;

    ctrl_t               ctrl;
    logic [PRE_BITS-1:0] prescale;
    logic [PRE_BITS-1:0] pre_cnt;
    logic [NUM_CHAN-1:0] status;

    logic [NUM_CHAN-1:0] en_vec;
    logic [NUM_CHAN-1:0] ar_vec;
    logic [NUM_CHAN-1:0] kill_c;
    logic [NUM_CHAN-1:0] run_c;
    logic [NUM_CHAN-1:0] expire_c;
    logic [NUM_CHAN-1:0] en_clr_c;
    logic [NUM_CHAN-1:0] w1c_c;
    logic                any_en_c;
    logic                tick_c;

    logic [DAT_W-1:0]    count  [NUM_CHAN];
    logic [DAT_W-1:0]    reload [NUM_CHAN];
    logic [DAT_W-1:0]    rdata_c;

    // Bus decode: an access commits on the edge that raises ack_o.
    assign sel_c    = stb_i & (adr_i[ADR_W-1:OFS_W] == BASEADR);
    assign commit_c = sel_c & ~ack_o;
    assign wr_c     = commit_c & we_i;
    assign rd_c     = commit_c & ~we_i;
    assign ofs      = adr_i[OFS_W-1:0];

    assign wr_ctrl_c      = wr_c & (ofs == REG_CTRL);
    assign wr_pre_c       = wr_c & (ofs == REG_PRESCALE);
    assign wr_stat_c      = wr_c & (ofs == REG_STATUS);
    assign ld_reload_c[0] = wr_c & (ofs == REG_RELOAD0);
    assign ld_reload_c[1] = wr_c & (ofs == REG_RELOAD1);
    assign ld_count_c[0]  = wr_c & (ofs == REG_COUNT0);
    assign ld_count_c[1]  = wr_c & (ofs == REG_COUNT1);

    assign en_vec = {ctrl.en1, ctrl.en0};
    assign ar_vec = {ctrl.ar1, ctrl.ar0};

    // A CTRL write dropping EN halts that channel in the same cycle, masking any expiry.
    assign kill_c = wr_ctrl_c ? ~{dat_i[CTRL_EN1], dat_i[CTRL_EN0]} : '0;
    assign run_c  = en_vec & ~kill_c;

    assign w1c_c  = wr_stat_c ? {dat_i[STAT_EXP1], dat_i[STAT_EXP0]} : '0;

    assign any_en_c = |en_vec;
    assign tick_c   = any_en_c & (pre_cnt == '0);

    // Prescaler: parked at PRESCALE while idle, otherwise counts down and ticks at zero.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            prescale <= '0;
            pre_cnt  <= '0;
        end else begin
            if (wr_pre_c) begin
                prescale <= dat_i[PRE_BITS-1:0];
                pre_cnt  <= dat_i[PRE_BITS-1:0];
            end else if (!any_en_c || (pre_cnt == '0)) begin
                pre_cnt <= prescale;
            end else begin
                pre_cnt <= pre_cnt - PRE_BITS'(1);
            end
        end
    end

    for (genvar k = 0; k < NUM_CHAN; k++) begin : g_chan
        wbt_chan u_chan (
            .clk       (clk),
            .arstn     (arstn),
            .tick      (tick_c),
            .en        (run_c[k]),
            .ar        (ar_vec[k]),
            .ld_count  (ld_count_c[k]),
            .ld_reload (ld_reload_c[k]),
            .wdata     (dat_i),
            .count     (count[k]),
            .reload    (reload[k]),
            .expire_c  (expire_c[k]),
            .en_clr_c  (en_clr_c[k])
        );
    end

    // CTRL: bus write wins; otherwise a non-reloading expiry drops its EN bit.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            ctrl <= '0;
        end else if (wr_ctrl_c) begin
            ctrl <= ctrl_t'(dat_i[$bits(ctrl_t)-1:0]);
        end else begin
            ctrl.en0 <= ctrl.en0 & ~en_clr_c[0];
            ctrl.en1 <= ctrl.en1 & ~en_clr_c[1];
        end
    end

    // STATUS is sticky; a fresh expiry beats a coincident write-1-to-clear.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            status <= '0;
            irq_o  <= '0;
        end else begin
            status <= (status & ~w1c_c) | expire_c;
            irq_o  <= expire_c;
        end
    end

    always_comb begin
        rdata_c = '0;
        case (ofs)
            REG_CTRL:     rdata_c = DAT_W'(ctrl);
            REG_PRESCALE: rdata_c = DAT_W'(prescale);
            REG_RELOAD0:  rdata_c = reload[0];
            REG_RELOAD1:  rdata_c = reload[1];
            REG_COUNT0:   rdata_c = count[0];
            REG_COUNT1:   rdata_c = count[1];
            REG_STATUS:   rdata_c = DAT_W'(status);
            REG_ID:       rdata_c = ID;
            default:      rdata_c = '0;
        endcase
    end

    // Ack and read data register together; dat_o holds until the next read.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            ack_o <= 1'b0;
            dat_o <= '0;
        end else begin
            ack_o <= commit_c;
            if (rd_c) begin
                dat_o <= rdata_c;
            end
        end
    end

endmodule

// File: tb/tb_wb_timer.sv
// Directed-vector bench for wb_timer: expected reads and irq strobes are queued, a monitor checks them.
module tb_wb_timer;

    logic        clk    = 1'b0;
    logic        arstn  = 1'b0;
    logic [14:0] adr_i  = '0;
    logic [31:0] dat_i  = '0;
    logic        we_i   = 1'b0;
    logic        stb_i  = 1'b0;
    logic [31:0] dat_o;
    logic        ack_o;
    logic [1:0]  irq_o;

    localparam logic [31:0] ID_VAL = 32'h574B5431;

    wb_timer dut (
        .clk   (clk),
        .arstn (arstn),
        .adr_i (adr_i),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .we_i  (we_i),
        .stb_i (stb_i),
        .ack_o (ack_o),
        .irq_o (irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        string       tag;
    } rd_exp_t;

    typedef struct {
        int         cyc;
        logic [1:0] bits;
    } irq_exp_t;

    rd_exp_t  exp_rd[$];
    irq_exp_t exp_irq[$];

    int   cyc         = 0;
    int   n_vec       = 0;
    int   n_err       = 0;
    int   last_commit = 0;
    logic cur_we      = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT acks a read or strobes irq_o.
    initial begin : monitor
        rd_exp_t  re;
        irq_exp_t ie;
        forever begin
            @(negedge clk);
            if (ack_o === 1'b1 && !cur_we) begin
                if (exp_rd.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_read_ack: got dat_o 0x%08h with no expected read (cycle %0d)", dat_o, cyc);
                end else begin
                    re = exp_rd.pop_front();
                    check(re.tag, dat_o, re.val);
                end
            end
            if (irq_o !== 2'b00) begin
                if (exp_irq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_irq: got irq_o %b, expected none (cycle %0d)", irq_o, cyc);
                end else begin
                    ie = exp_irq.pop_front();
                    check("irq_cycle", 32'(cyc), 32'(ie.cyc));
                    check("irq_bits", 32'(irq_o), 32'(ie.bits));
                end
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One Wishbone access at BASEADR; records the commit cycle and checks one-cycle ack latency.
    task automatic bus_xfer(input logic [14:0] adr, input logic we, input logic [31:0] wd);
        int waited;
        @(negedge clk);
        adr_i  = adr;
        we_i   = we;
        dat_i  = wd;
        stb_i  = 1'b1;
        cur_we = we;
        waited = 0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (ack_o !== 1'b1 && waited < 8);
        check("ack_latency", 32'(waited), 32'd1);
        last_commit = cyc;
        stb_i = 1'b0;
        we_i  = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] ofs, input logic [31:0] d);
        bus_xfer({11'h000, ofs}, 1'b1, d);
    endtask

    task automatic rd(input logic [3:0] ofs, input logic [31:0] exp, input string tag);
        exp_rd.push_back('{val: exp, tag: tag});
        bus_xfer({11'h000, ofs}, 1'b0, 32'h0);
    endtask

    task automatic push_irq(input int c, input logic [1:0] b);
        exp_irq.push_back('{cyc: c, bits: b});
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int         e;
        int         acks;
        logic [5:0] pat;

        repeat (3) @(negedge clk);
        check("reset_dat_o", dat_o, 32'h0);
        check("reset_ack_o", 32'(ack_o), 32'h0);
        check("reset_irq_o", 32'(irq_o), 32'h0);
        arstn = 1'b1;

        // ID, unmapped offset and reset register values
        rd(4'h7, ID_VAL, "t1_id");
        rd(4'hF, 32'h0, "t1_unmapped");
        rd(4'h0, 32'h0, "t1_ctrl_reset");
        rd(4'h1, 32'h0, "t1_prescale_reset");
        rd(4'h6, 32'h0, "t1_status_reset");

        // One-shot: PRESCALE=3, COUNT0=4 -> irq 20 clocks after the EN commit
        wr(4'h1, 32'd3);
        wr(4'h4, 32'd4);
        wr(4'h0, 32'h1);
        e = last_commit;
        push_irq(e + 20, 2'b01);
        wait_until(e + 25);
        rd(4'h6, 32'h1, "t2_status_exp0");
        rd(4'h0, 32'h0, "t2_ctrl_en0_cleared");
        rd(4'h4, 32'h0, "t2_count0_zero");
        wait_until(e + 225);
        check("t2_irq_queue_empty", 32'(exp_irq.size()), 32'd0);
        wr(4'h6, 32'h1);
        rd(4'h6, 32'h0, "t2_status_cleared");

        // Auto-reload on channel 1 with PRESCALE=0: period 10 clocks
        wr(4'h1, 32'd0);
        wr(4'h3, 32'd9);
        wr(4'h5, 32'd9);
        wr(4'h0, 32'hA);
        e = last_commit;
        for (int k = 1; k <= 11; k++) push_irq(e + 10 * k, 2'b10);
        wait_until(e + 101);
        wr(4'h6, 32'h2);
        rd(4'h6, 32'h0, "t3_exp1_cleared");
        wait_until(e + 111);
        rd(4'h6, 32'h2, "t3_exp1_set_again");
        wr(4'h0, 32'h0);
        wait_until(e + 140);
        check("t3_irq_queue_empty", 32'(exp_irq.size()), 32'd0);
        wr(4'h6, 32'h3);

        // Both channels expire together; W1C lands on the expiry edge
        wr(4'h1, 32'd1);
        wr(4'h4, 32'd2);
        wr(4'h5, 32'd2);
        wr(4'h0, 32'h3);
        e = last_commit;
        push_irq(e + 6, 2'b11);
        wait_until(e + 5);
        wr(4'h6, 32'h3);
        rd(4'h6, 32'h3, "t4_status_set_wins");
        rd(4'h0, 32'h0, "t4_ctrl_cleared");
        wr(4'h6, 32'h3);
        rd(4'h6, 32'h0, "t4_status_cleared");
        check("t4_irq_queue_empty", 32'(exp_irq.size()), 32'd0);

        // Held strobe: acks alternate, every ack is a read of ID
        for (int k = 0; k < 3; k++) exp_rd.push_back('{val: ID_VAL, tag: "t5_held_id"});
        @(negedge clk);
        adr_i  = 15'h007;
        we_i   = 1'b0;
        stb_i  = 1'b1;
        cur_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pat[i] = ack_o;
            @(negedge clk);
        end
        stb_i = 1'b0;
        check("t5_ack_pattern", 32'(pat), 32'b101010);

        // Strobe outside the register window: no ack, no CTRL change
        @(negedge clk);
        adr_i  = 15'h010;
        we_i   = 1'b1;
        dat_i  = 32'hF;
        stb_i  = 1'b1;
        cur_we = 1'b1;
        acks   = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack_o === 1'b1) acks++;
        end
        stb_i = 1'b0;
        we_i  = 1'b0;
        check("t5_foreign_ack_count", 32'(acks), 32'd0);
        rd(4'h0, 32'h0, "t5_ctrl_after_foreign");

        // Asynchronous reset in the middle of a count
        rd(4'h7, ID_VAL, "t6_id_before_reset");
        wr(4'h4, 32'd50);
        wr(4'h0, 32'h1);
        e = last_commit;
        wait_until(e + 10);
        #2;
        arstn = 1'b0;
        #1;
        check("t6_dat_o_async", dat_o, 32'h0);
        check("t6_ack_o_async", 32'(ack_o), 32'h0);
        check("t6_irq_o_async", 32'(irq_o), 32'h0);
        repeat (2) @(negedge clk);
        arstn = 1'b1;
        rd(4'h0, 32'h0, "t6_ctrl_after_reset");
        rd(4'h4, 32'h0, "t6_count0_after_reset");
        rd(4'h1, 32'h0, "t6_prescale_after_reset");
        e = cyc;
        wait_until(e + 100);
        check("t6_irq_queue_empty", 32'(exp_irq.size()), 32'd0);
        check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
